tdc_histogrammer: RTL and testbench

Start–stop time-correlation histogrammer that sits directly downstream of the per-channel pulse shapers. It consumes single-cycle, dead-time-limited pulses from a start channel (excitation/sync) and a stop channel (photon detector). For each start it measures the start-to-first-stop delay in 500 MHz clock cycles and accumulates a saturating per-bin count. Host logic reads bins through a registered read port.

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_histogrammer_hist_bank.sv | 50 +++++
 rtl/tdc_histogrammer.sv | 190 +++++++++++++++++++
 tb/tb_tdc_histogrammer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// start-stop time-correlation histogrammer.
package tdc_pkg;

   localparam int NBINS_DEF = 64;
   localparam int BIN_W_DEF = 6;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      IDLE   = 2'd1,
      ARMED  = 2'd2,
      TIMING = 2'd3
   } tdc_state_t;

   // Counters of any width up to 32 bits pass through here zero-extended and
   // come back truncated by the caller; the value sticks at the all-ones limit.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] w_max;
      w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= w_max) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/tdc_histogrammer_hist_bank.sv
// Histogram storage: one write port (sweep zero-write or saturating increment)
// and one registered read port that returns the pre-write value on a collision.
module hist_bank
   import tdc_pkg::*;
#(
   parameter int NBINS = NBINS_DEF,
   parameter int BIN_W = BIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_zero_en,
   input  logic [BIN_W-1:0] i_zero_idx,
   input  logic             i_inc_en,
   input  logic [BIN_W-1:0] i_inc_idx,
   input  logic             i_rd_en,
   input  logic [BIN_W-1:0] i_rd_addr,
   output logic             o_rd_valid,
   output logic [CNT_W-1:0] o_rd_data
);

   logic [CNT_W-1:0] r_mem [NBINS];
   logic             r_rd_valid;
   logic [CNT_W-1:0] r_rd_data;

   // The array carries no reset; the clear sweep that follows every reset zeroes it.
   always_ff @(posedge i_clk) begin
      if (i_zero_en) begin
         r_mem[i_zero_idx] <= '0;
      end else if (i_inc_en) begin
         r_mem[i_inc_idx] <= CNT_W'(sat_inc(32'(r_mem[i_inc_idx]), CNT_W));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
         end
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/tdc_histogrammer.sv
// Start-stop histogrammer top: acquisition FSM, delay counter, event counters
// and the clear sweep; bin storage lives in hist_bank.
module tdc_histogrammer
   import tdc_pkg::*;
#(
   parameter int NBINS = NBINS_DEF,
   parameter int BIN_W = BIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start_pulse,
   input  logic             i_stop_pulse,
   input  logic             i_acq_en,
   input  logic             i_clear,
   input  logic             i_rd_req,
   input  logic [BIN_W-1:0] i_rd_addr,
   output logic             o_rd_valid,
   output logic [CNT_W-1:0] o_rd_data,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_start_cnt,
   output logic [CNT_W-1:0] o_timeout_cnt
);

   tdc_state_t       r_state;
   tdc_state_t       w_next_state;
   logic [BIN_W-1:0] r_d;
   logic [BIN_W-1:0] r_sweep_idx;
   logic [CNT_W-1:0] r_start_cnt;
   logic [CNT_W-1:0] r_timeout_cnt;
   logic             r_inc_valid;
   logic [BIN_W-1:0] r_inc_idx;

   logic             w_start_acc;
   logic             w_stop_acc;
   logic [BIN_W-1:0] w_stop_idx;
   logic             w_timeout;
   logic             w_d_terminal;
   logic             w_sweep_last;
   logic             w_rd_en;

   assign w_d_terminal = (r_d == BIN_W'(NBINS - 1));
   assign w_sweep_last = (r_sweep_idx == BIN_W'(NBINS - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A stop arriving together with a start is credited to the window already
   // open (bin d); only in ARMED, with no window open, does it land in bin 0.
   always_comb begin
      w_next_state = r_state;
      w_start_acc  = 1'b0;
      w_stop_acc   = 1'b0;
      w_stop_idx   = '0;
      w_timeout    = 1'b0;
      if (i_clear) begin
         w_next_state = CLEAR;
      end else begin
         unique case (r_state)
            CLEAR: begin
               if (w_sweep_last) begin
                  w_next_state = i_acq_en ? ARMED : IDLE;
               end
            end
            IDLE: begin
               if (i_acq_en) begin
                  w_next_state = ARMED;
               end
            end
            ARMED: begin
               if (!i_acq_en) begin
                  w_next_state = IDLE;
               end else if (i_start_pulse) begin
                  w_start_acc = 1'b1;
                  if (i_stop_pulse) begin
                     w_stop_acc = 1'b1;
                     w_stop_idx = '0;
                  end else begin
                     w_next_state = TIMING;
                  end
               end
            end
            TIMING: begin
               if (!i_acq_en) begin
                  w_next_state = IDLE;
               end else begin
                  if (i_stop_pulse) begin
                     w_stop_acc = 1'b1;
                     w_stop_idx = r_d;
                  end
                  if (i_start_pulse) begin
                     w_start_acc  = 1'b1;
                     w_next_state = TIMING;
                  end else if (i_stop_pulse) begin
                     w_next_state = ARMED;
                  end else if (w_d_terminal) begin
                     w_timeout    = 1'b1;
                     w_next_state = ARMED;
                  end
               end
            end
            default: begin
               w_next_state = CLEAR;
            end
         endcase
      end
   end

   // r_d holds the delay a stop sampled at the coming edge would have, so a
   // new window loads 1 (its start cycle was delay 0).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_d <= '0;
      end else if (w_start_acc) begin
         r_d <= BIN_W'(1);
      end else if (r_state == TIMING) begin
         r_d <= r_d + BIN_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sweep_idx <= '0;
      end else if (i_clear || (r_state != CLEAR)) begin
         r_sweep_idx <= '0;
      end else begin
         r_sweep_idx <= r_sweep_idx + BIN_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_start_cnt   <= '0;
         r_timeout_cnt <= '0;
      end else if (r_state == CLEAR) begin
         r_start_cnt   <= '0;
         r_timeout_cnt <= '0;
      end else begin
         if (w_start_acc) begin
            r_start_cnt <= CNT_W'(sat_inc(32'(r_start_cnt), CNT_W));
         end
         if (w_timeout) begin
            r_timeout_cnt <= CNT_W'(sat_inc(32'(r_timeout_cnt), CNT_W));
         end
      end
   end

   // The increment is queued one cycle so the bank only ever sees a
   // registered index; leaving acquisition does not cancel a queued one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inc_valid <= 1'b0;
         r_inc_idx   <= '0;
      end else begin
         r_inc_valid <= w_stop_acc;
         if (w_stop_acc) begin
            r_inc_idx <= w_stop_idx;
         end
      end
   end

   assign w_rd_en = i_rd_req && (r_state != CLEAR);

   hist_bank #(
      .NBINS (NBINS),
      .BIN_W (BIN_W),
      .CNT_W (CNT_W)
   ) u_hist_bank (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_zero_en  (r_state == CLEAR),
      .i_zero_idx (r_sweep_idx),
      .i_inc_en   (r_inc_valid),
      .i_inc_idx  (r_inc_idx),
      .i_rd_en    (w_rd_en),
      .i_rd_addr  (i_rd_addr),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data)
   );

   assign o_busy        = (r_state == CLEAR);
   assign o_start_cnt   = r_start_cnt;
   assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_tdc_histogrammer.sv
// Self-checking bench for tdc_histogrammer: directed scenarios plus random
// pulse trains, all compared against a window-based reference model.
module tb_tdc_histogrammer;

   localparam int NBINS   = 64;
   localparam int BIN_W   = 6;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int SEQ_MAX = 512;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_pulse;
   logic             stop_pulse;
   logic             acq_en;
   logic             clear;
   logic             rd_req;
   logic [BIN_W-1:0] rd_addr;
   logic             rd_valid;
   logic [CNT_W-1:0] rd_data;
   logic             busy;
   logic [CNT_W-1:0] start_cnt;
   logic [CNT_W-1:0] timeout_cnt;

   int checks = 0;
   int errors = 0;

   int model_bins [NBINS];
   int model_start;
   int model_timeout;

   bit seq_start [SEQ_MAX];
   bit seq_stop  [SEQ_MAX];

   logic [CNT_W-1:0] dut_bins  [NBINS];
   logic             dut_valid [NBINS];

   always #1 clk = ~clk;

   tdc_histogrammer #(
      .NBINS (NBINS),
      .BIN_W (BIN_W),
      .CNT_W (CNT_W)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start_pulse (start_pulse),
      .i_stop_pulse  (stop_pulse),
      .i_acq_en      (acq_en),
      .i_clear       (clear),
      .i_rd_req      (rd_req),
      .i_rd_addr     (rd_addr),
      .o_rd_valid    (rd_valid),
      .o_rd_data     (rd_data),
      .o_busy        (busy),
      .o_start_cnt   (start_cnt),
      .o_timeout_cnt (timeout_cnt)
   );

   initial begin
      #150000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NBINS; i++) model_bins[i] = 0;
      model_start   = 0;
      model_timeout = 0;
   endfunction

   function automatic void seq_clear();
      for (int i = 0; i < SEQ_MAX; i++) begin
         seq_start[i] = 1'b0;
         seq_stop[i]  = 1'b0;
      end
   endfunction

   // A window opens at each start and closes on its first stop, on the next
   // start, or once NBINS cycles pass without a stop (a timeout).
   function automatic void model_run(input int len);
      bit open;
      int ts;
      bit s;
      bit p;
      bit credited;
      open = 1'b0;
      ts   = 0;
      for (int c = 0; c < len + NBINS + 4; c++) begin
         s        = (c < len) ? seq_start[c] : 1'b0;
         p        = (c < len) ? seq_stop[c]  : 1'b0;
         credited = 1'b0;
         if (open && (c - ts >= NBINS)) begin
            model_timeout = sat(model_timeout);
            open = 1'b0;
         end
         if (p && open) begin
            model_bins[c - ts] = sat(model_bins[c - ts]);
            open     = 1'b0;
            credited = 1'b1;
         end
         if (s) begin
            model_start = sat(model_start);
            if (p && !credited) begin
               model_bins[0] = sat(model_bins[0]);
            end else begin
               open = 1'b1;
               ts   = c;
            end
         end
      end
   endfunction

   task automatic applyStimulus(input int len);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         start_pulse = seq_start[c];
         stop_pulse  = seq_stop[c];
      end
      @(negedge clk);
      start_pulse = 1'b0;
      stop_pulse  = 1'b0;
      repeat (NBINS + 8) @(negedge clk);
      model_run(len);
   endtask

   task automatic read_bin(input int idx, output logic [CNT_W-1:0] d, output logic v);
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = BIN_W'(idx);
      @(negedge clk);
      v      = rd_valid;
      d      = rd_data;
      rd_req = 1'b0;
   endtask

   task automatic read_all();
      logic [CNT_W-1:0] d;
      logic             v;
      for (int i = 0; i < NBINS; i++) begin
         read_bin(i, d, v);
         dut_bins[i]  = d;
         dut_valid[i] = v;
      end
   endtask

   task automatic do_clear();
      int n;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_done: busy=%b after %0d cycles, expected 0", busy, n);
      end
      model_reset();
   endtask

   task automatic test_reset();
      int n;
      rst_n       = 1'b0;
      start_pulse = 1'b0;
      stop_pulse  = 1'b0;
      acq_en      = 1'b1;
      clear       = 1'b0;
      rd_req      = 1'b0;
      rd_addr     = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, rd_valid, rd_data, start_cnt, timeout_cnt} !== {1'b1, 1'b0, 12'h000}) begin
         errors++;
         $display("[TB] FAIL reset_values: busy=%b rd_valid=%b rd_data=%0d start=%0d timeout=%0d, expected 1 0 0 0 0",
                  busy, rd_valid, rd_data, start_cnt, timeout_cnt);
      end
      rst_n = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != NBINS) begin
         errors++;
         $display("[TB] FAIL reset_busy_len: busy high %0d cycles, expected %0d", n, NBINS);
      end
      model_reset();
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bin%0d: valid=%b data=%0d, expected valid=1 data=0", i, dut_valid[i], dut_bins[i]);
         end
      end
      checks++;
      if (start_cnt !== '0 || timeout_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL reset_counters: start=%0d timeout=%0d, expected 0 0", start_cnt, timeout_cnt);
      end
   endtask

   task automatic test_single_stop();
      do_clear();
      seq_clear();
      seq_start[2] = 1'b1;
      seq_stop[12] = 1'b1;
      seq_stop[14] = 1'b1;
      applyStimulus(20);
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== CNT_W'(model_bins[i])) begin
            errors++;
            $display("[TB] FAIL single_bin%0d: valid=%b data=%0d, expected 1/%0d", i, dut_valid[i], dut_bins[i], model_bins[i]);
         end
      end
      checks++;
      if (dut_bins[10] !== 4'd1 || dut_bins[12] !== 4'd0) begin
         errors++;
         $display("[TB] FAIL single_key_bins: bin10=%0d bin12=%0d, expected 1 0", dut_bins[10], dut_bins[12]);
      end
      checks++;
      if (start_cnt !== 4'd1 || timeout_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL single_counters: start=%0d timeout=%0d, expected 1 0", start_cnt, timeout_cnt);
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_valid_pulse: rd_valid=%b one cycle after read, expected 0", rd_valid);
      end
   endtask

   task automatic test_same_cycle_and_edge();
      do_clear();
      seq_clear();
      seq_start[2]  = 1'b1;
      seq_stop[2]   = 1'b1;
      seq_start[10] = 1'b1;
      seq_stop[73]  = 1'b1;
      applyStimulus(80);
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== CNT_W'(model_bins[i])) begin
            errors++;
            $display("[TB] FAIL edge_bin%0d: valid=%b data=%0d, expected 1/%0d", i, dut_valid[i], dut_bins[i], model_bins[i]);
         end
      end
      checks++;
      if (dut_bins[0] !== 4'd1 || dut_bins[63] !== 4'd1 || start_cnt !== 4'd2 || timeout_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL edge_key: bin0=%0d bin63=%0d start=%0d timeout=%0d, expected 1 1 2 0",
                  dut_bins[0], dut_bins[63], start_cnt, timeout_cnt);
      end
   endtask

   task automatic test_timeout();
      do_clear();
      seq_clear();
      seq_start[2] = 1'b1;
      seq_stop[66] = 1'b1;
      applyStimulus(70);
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== '0) begin
            errors++;
            $display("[TB] FAIL timeout_bin%0d: valid=%b data=%0d, expected 1/0", i, dut_valid[i], dut_bins[i]);
         end
      end
      checks++;
      if (timeout_cnt !== 4'd1 || start_cnt !== 4'd1 || model_timeout != 1) begin
         errors++;
         $display("[TB] FAIL timeout_counters: start=%0d timeout=%0d, expected 1 1", start_cnt, timeout_cnt);
      end
   endtask

   task automatic test_retrigger();
      do_clear();
      seq_clear();
      seq_start[2]   = 1'b1;
      seq_start[22]  = 1'b1;
      seq_stop[27]   = 1'b1;
      seq_start[100] = 1'b1;
      seq_start[107] = 1'b1;
      seq_stop[107]  = 1'b1;
      seq_stop[110]  = 1'b1;
      applyStimulus(120);
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== CNT_W'(model_bins[i])) begin
            errors++;
            $display("[TB] FAIL retrig_bin%0d: valid=%b data=%0d, expected 1/%0d", i, dut_valid[i], dut_bins[i], model_bins[i]);
         end
      end
      checks++;
      if (dut_bins[5] !== 4'd1 || dut_bins[7] !== 4'd1 || dut_bins[3] !== 4'd1 ||
          start_cnt !== 4'd4 || timeout_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL retrig_key: bin5=%0d bin7=%0d bin3=%0d start=%0d timeout=%0d, expected 1 1 1 4 0",
                  dut_bins[5], dut_bins[7], dut_bins[3], start_cnt, timeout_cnt);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         do_clear();
         seq_clear();
         for (int c = 0; c < 300; c++) begin
            seq_start[c] = ($urandom_range(0, 29) == 0);
            seq_stop[c]  = ($urandom_range(0, 7) == 0);
         end
         applyStimulus(300);
         read_all();
         for (int i = 0; i < NBINS; i++) begin
            checks++;
            if (dut_valid[i] !== 1'b1 || dut_bins[i] !== CNT_W'(model_bins[i])) begin
               errors++;
               $display("[TB] FAIL random%0d_bin%0d: valid=%b data=%0d, expected 1/%0d",
                        r, i, dut_valid[i], dut_bins[i], model_bins[i]);
            end
         end
         checks++;
         if (start_cnt !== CNT_W'(model_start) || timeout_cnt !== CNT_W'(model_timeout)) begin
            errors++;
            $display("[TB] FAIL random%0d_counters: start=%0d timeout=%0d, expected %0d %0d",
                     r, start_cnt, timeout_cnt, model_start, model_timeout);
         end
      end
   endtask

   task automatic test_saturation();
      do_clear();
      seq_clear();
      for (int k = 0; k < 20; k++) begin
         seq_start[10 * k + 2] = 1'b1;
         seq_stop[10 * k + 7]  = 1'b1;
      end
      applyStimulus(205);
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== CNT_W'(model_bins[i])) begin
            errors++;
            $display("[TB] FAIL sat_bin%0d: valid=%b data=%0d, expected 1/%0d", i, dut_valid[i], dut_bins[i], model_bins[i]);
         end
      end
      checks++;
      if (dut_bins[5] !== 4'd15 || start_cnt !== 4'd15 || timeout_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL sat_key: bin5=%0d start=%0d timeout=%0d, expected 15 15 0", dut_bins[5], start_cnt, timeout_cnt);
      end
   endtask

   task automatic test_clear();
      int n;
      bit saw_valid;
      do_clear();
      seq_clear();
      seq_start[2] = 1'b1;
      seq_stop[7]  = 1'b1;
      applyStimulus(10);
      @(negedge clk);
      start_pulse = 1'b1;
      @(negedge clk);
      start_pulse = 1'b0;
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear   = 1'b0;
      rd_req  = 1'b1;
      rd_addr = BIN_W'(5);
      n = 0;
      saw_valid = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         if (rd_valid !== 1'b0) saw_valid = 1'b1;
         rd_req = 1'b0;
      end
      checks++;
      if (n != NBINS) begin
         errors++;
         $display("[TB] FAIL clear_busy_len: busy high %0d cycles, expected %0d", n, NBINS);
      end
      checks++;
      if (saw_valid) begin
         errors++;
         $display("[TB] FAIL clear_read_blocked: rd_valid=1 seen during sweep, expected 0");
      end
      model_reset();
      read_all();
      for (int i = 0; i < NBINS; i++) begin
         checks++;
         if (dut_valid[i] !== 1'b1 || dut_bins[i] !== '0) begin
            errors++;
            $display("[TB] FAIL clear_bin%0d: valid=%b data=%0d, expected 1/0", i, dut_valid[i], dut_bins[i]);
         end
      end
      checks++;
      if (start_cnt !== '0 || timeout_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL clear_counters: start=%0d timeout=%0d, expected 0 0", start_cnt, timeout_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_stop();
      test_same_cycle_and_edge();
      test_timeout();
      test_retrigger();
      test_random();
      test_saturation();
      test_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
